// File: rtl/cart_rom_arbiter.sv
// cart_rom_arbiter: shares one single-port cart ROM between the download writer and two GB cart read ports
module cart_rom_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_req,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  output logic              dn_ack,
  input  logic              rq1_req,
  input  logic [ADDR_W-1:0] rq1_addr,
  output logic              rq1_ack,
  output logic [DATA_W-1:0] rq1_data,
  input  logic              rq2_req,
  input  logic [ADDR_W-1:0] rq2_addr,
  output logic              rq2_ack,
  output logic [DATA_W-1:0] rq2_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
  localparam int CW = $clog2(RD_LAT + 2);
  localparam logic [CW-1:0] LAST = CW'(RD_LAT);
  state_t state;
  logic [CW-1:0] cnt;
  logic last2;
  logic pick2;
  // gb2 wins when it is the only reader or when gb1 was served last
  always_comb pick2 = rq2_req & (~rq1_req | ~last2);
  // arbitration FSM: download first, then round-robin reads, one ack cycle per access
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last2    <= 1'b1;
      dn_ack   <= 1'b0;
      rq1_ack  <= 1'b0;
      rq2_ack  <= 1'b0;
      rq1_data <= '0;
      rq2_data <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      busy     <= 1'b0;
      grant    <= 2'd0;
    end else begin
      dn_ack  <= 1'b0;
      rq1_ack <= 1'b0;
      rq2_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dn_req) begin
            mem_addr <= dn_addr;
            mem_din  <= dn_data;
            mem_we   <= 1'b1;
            grant    <= 2'd3;
            busy     <= 1'b1;
            state    <= WR;
          end else if (rq1_req | rq2_req) begin
            mem_addr <= pick2 ? rq2_addr : rq1_addr;
            grant    <= pick2 ? 2'd2 : 2'd1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= RD;
          end
        end
        WR: begin
          mem_we <= 1'b0;
          dn_ack <= 1'b1;
          state  <= ACK;
        end
        RD: begin
          if (cnt == LAST) begin
            if (grant == 2'd2) begin
              rq2_data <= mem_dout;
              rq2_ack  <= 1'b1;
            end else begin
              rq1_data <= mem_dout;
              rq1_ack  <= 1'b1;
            end
            last2 <= grant == 2'd2;
            state <= ACK;
          end else cnt <= cnt + CW'(1);
        end
        ACK: begin
          grant <= 2'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
